text_pixel_pipeline: RTL and testbench

Converts raster position from the video timing generator into 24-bit pixels for the DVI encoder. The block sits between the character buffer RAM and the font ROM: it addresses the character buffer, drives the font ROM with character code and scanline, and serializes the returned 8-pixel row into foreground/background colour. All sync and enable signals are delayed to match a fixed pipeline latency, so the downstream encoder sees aligned video.

---
 rtl/text_pkg.sv | 10 +
 rtl/text_pixel_pipeline_if.sv | 20 ++
 rtl/text_pixel_pipeline_cursor_blink.sv | 36 +++
 rtl/text_pixel_pipeline.sv | 134 +++++++++++++
 tb/tb_text_pixel_pipeline.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
package text_pkg;
    localparam int CHAR_W   = 8;
    localparam int CHAR_H   = 16;
    localparam int PIPE_LAT = 4;
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    typedef logic [23:0] rgb888_t;
endpackage

// File: rtl/text_pixel_pipeline_if.sv
// Memory-side bus of the text pipeline: character RAM address/data and font ROM drive/data.
// No handshake: both memories are free-running with exactly one cycle of read latency,
// data returned on the cycle after the address/code is presented.
interface text_pixel_pipeline_if;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [7:0]  font_char;
    logic [3:0]  font_scanline;
    logic [7:0]  font_row;

    modport master (
        output char_addr, font_char, font_scanline,
        input  char_data, font_row
    );

    modport slave (
        input  char_addr, font_char, font_scanline,
        output char_data, font_row
    );
endinterface

// File: rtl/text_pixel_pipeline_cursor_blink.sv
// Cursor blink generator: counts vsync rising edges modulo BLINK_FRAMES; on for the first half.
// Only instantiated when TEXT_CURSOR_EN is defined.
module cursor_blink #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_i,
    output logic blink_on_o
);
    localparam int CW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] HALF = CW'(BLINK_FRAMES / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          vs_prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (vsync_i && !vs_prev_q) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            vs_prev_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            vs_prev_q <= vsync_i;
        end
    end

    assign blink_on_o = (cnt_q < HALF);
endmodule

// File: rtl/text_pixel_pipeline.sv
// Text-mode renderer: raster position -> char RAM -> font ROM -> RGB888, fixed 4-cycle latency.
// Optional blinking cursor inversion is enabled by defining TEXT_CURSOR_EN.
module text_pixel_pipeline
    import text_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   h_count,
    input  logic [9:0]                   v_count,
    input  logic                         video_active,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    text_pixel_pipeline_if.master        mem,
    input  rgb888_t                      fg_color,
    input  rgb888_t                      bg_color,
    input  logic [6:0]                   cursor_col,
    input  logic [4:0]                   cursor_row,
    input  logic                         cursor_en,
    output rgb888_t                      pixel_rgb,
    output logic                         de_out,
    output logic                         hsync_out,
    output logic                         vsync_out
);
    localparam logic [7:0] COLS_L = 8'(COLS);
    localparam logic [5:0] ROWS_L = 6'(ROWS);

    logic [6:0]  col;
    logic [2:0]  xbit;
    logic [4:0]  row;
    logic [3:0]  scan;
    logic        in_range;
    logic        hit_d;
    logic [11:0] addr_d;

    logic [11:0]         char_addr_q;
    logic [3:0]          scan0_q, scan1_q;
    logic [2:0]          xbit0_q, xbit1_q, xbit2_q;
    logic [2:0]          inr_q;
    logic [2:0]          hit_q;
    logic                run_q;
    logic [PIPE_LAT-1:0] de_sr_q, hs_sr_q, vs_sr_q;
    rgb888_t             pixel_q, pixel_d;
    logic                pix;

    assign col      = h_count[9:3];
    assign xbit     = h_count[2:0];
    assign row      = v_count[8:4];
    assign scan     = v_count[3:0];
    assign in_range = ({1'b0, col} < COLS_L) && ({1'b0, row} < ROWS_L);

    // row*80 + col as row*64 + row*16 + col; the address holds outside the visible text area.
    assign addr_d = (video_active && in_range)
                  ? ({1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col})
                  : char_addr_q;

    logic unused_vmsb;
    assign unused_vmsb = v_count[9];

`ifdef TEXT_CURSOR_EN
    logic blink_on;

    cursor_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_cursor_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync_i    (vsync_in),
        .blink_on_o (blink_on)
    );

    assign hit_d = cursor_en && blink_on && (col == cursor_col) && (row == cursor_row)
                && (scan[3:1] == 3'b111);
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_col, cursor_row, cursor_en, 32'(BLINK_FRAMES)};
    assign hit_d = 1'b0;
`endif

    always_comb begin
        pix     = mem.font_row[3'd7 - xbit2_q];
        pixel_d = bg_color;
        if (!de_sr_q[PIPE_LAT-2]) begin
            pixel_d = '0;
        end else if (inr_q[2] && (pix ^ hit_q[2])) begin
            pixel_d = fg_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_addr_q <= '0;
            scan0_q     <= '0;
            scan1_q     <= '0;
            xbit0_q     <= '0;
            xbit1_q     <= '0;
            xbit2_q     <= '0;
            inr_q       <= '0;
            hit_q       <= '0;
            run_q       <= 1'b0;
            de_sr_q     <= '0;
            hs_sr_q     <= '0;
            vs_sr_q     <= '0;
            pixel_q     <= '0;
        end else begin
            char_addr_q <= addr_d;
            scan0_q     <= scan;
            scan1_q     <= scan0_q;
            xbit0_q     <= xbit;
            xbit1_q     <= xbit0_q;
            xbit2_q     <= xbit1_q;
            inr_q       <= {inr_q[1:0], in_range};
            hit_q       <= {hit_q[1:0], hit_d};
            run_q       <= 1'b1;
            de_sr_q     <= {de_sr_q[PIPE_LAT-2:0], video_active};
            hs_sr_q     <= {hs_sr_q[PIPE_LAT-2:0], hsync_in};
            vs_sr_q     <= {vs_sr_q[PIPE_LAT-2:0], vsync_in};
            pixel_q     <= pixel_d;
        end
    end

    // run_q masks whatever the RAM returns while the pipeline is held in reset.
    assign mem.char_addr     = char_addr_q;
    assign mem.font_char     = run_q ? mem.char_data : 8'h00;
    assign mem.font_scanline = scan1_q;

    assign pixel_rgb = pixel_q;
    assign de_out    = de_sr_q[PIPE_LAT-1];
    assign hsync_out = hs_sr_q[PIPE_LAT-1];
    assign vsync_out = vs_sr_q[PIPE_LAT-1];
endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Bench for text_pixel_pipeline: RAM/ROM models, a cell-level reference model checked every cycle,
// plus directed literal checks; cursor checks run when TEXT_CURSOR_EN is defined.
module tb_text_pixel_pipeline;
    import text_pkg::*;

    localparam int BF = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_count = '0, v_count = '0;
    logic       video_active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    rgb888_t    fg_color = '0, bg_color = '0;
    logic [6:0] cursor_col = '0;
    logic [4:0] cursor_row = '0;
    logic       cursor_en = 1'b0;
    rgb888_t    pixel_rgb;
    logic       de_out, hsync_out, vsync_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    text_pixel_pipeline_if mem ();

    text_pixel_pipeline dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_count      (h_count),
        .v_count      (v_count),
        .video_active (video_active),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .mem          (mem),
        .fg_color     (fg_color),
        .bg_color     (bg_color),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .cursor_en    (cursor_en),
        .pixel_rgb    (pixel_rgb),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    logic [7:0] ram [0:4095];

    function automatic logic [7:0] rom_f(input logic [7:0] c, input logic [3:0] s);
        if (c == 8'h41 && s == 4'd5) return 8'h81;
        return c ^ {s, s} ^ 8'h3C;
    endfunction

    always @(posedge clk) mem.char_data <= ram[mem.char_addr];
    always @(posedge clk) mem.font_row  <= rom_f(mem.font_char, mem.font_scanline);

    // One record per input cycle, judged at the character-cell level.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       inr;
        logic       pix;
        logic       hit;
        logic [3:0] scan;
    } rec_t;

    rec_t        hist [4];
    logic [11:0] m_addr = '0;
    int          m_cnt = 0;
    logic        m_vprev = 1'b0;
    logic [7:0]  exp_fc;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        rec_t        r;
        logic [11:0] prev_addr;
        int          col, row;
        logic [7:0]  code, fr;
        logic        blink;
        rgb888_t     exp_pix;
        @(posedge clk);
        col       = int'(h_count[9:3]);
        row       = int'(v_count[8:4]);
        prev_addr = m_addr;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = '0;
            m_addr  = '0;
            m_cnt   = 0;
            m_vprev = 1'b0;
            exp_fc  = 8'h00;
        end else begin
            r      = '0;
            r.de   = video_active;
            r.hs   = hsync_in;
            r.vs   = vsync_in;
            r.inr  = (col < 80) && (row < 30);
            r.scan = v_count[3:0];
            code   = ram[row * 80 + col];
            fr     = rom_f(code, v_count[3:0]);
            r.pix  = fr[3'd7 - h_count[2:0]];
            blink  = (m_cnt < BF / 2);
`ifdef TEXT_CURSOR_EN
            r.hit  = cursor_en && blink && (h_count[9:3] == cursor_col)
                  && (v_count[8:4] == cursor_row) && (v_count[3:0] >= 4'd14);
`else
            r.hit  = 1'b0;
`endif
            if (vsync_in && !m_vprev) m_cnt = (m_cnt + 1) % BF;
            m_vprev = vsync_in;
            if (video_active && r.inr) m_addr = 12'(row * 80 + col);
            exp_fc = ram[prev_addr];
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = r;
        end
        #1;
        if (!hist[3].de) exp_pix = '0;
        else if (hist[3].inr && (hist[3].pix ^ hist[3].hit)) exp_pix = fg_color;
        else exp_pix = bg_color;
        chk("pixel_rgb", pixel_rgb, exp_pix);
        chk("de_out", 24'(de_out), 24'(hist[3].de));
        chk("hsync_out", 24'(hsync_out), 24'(hist[3].hs));
        chk("vsync_out", 24'(vsync_out), 24'(hist[3].vs));
        chk("char_addr", 24'(mem.char_addr), 24'(m_addr));
        chk("font_char", 24'(mem.font_char), 24'(exp_fc));
        chk("font_scanline", 24'(mem.font_scanline), 24'(hist[1].scan));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pix"}, pixel_rgb, 24'h0);
        chk({name, "_de"}, 24'(de_out), 24'h0);
        chk({name, "_hs"}, 24'(hsync_out), 24'h0);
        chk({name, "_vs"}, 24'(vsync_out), 24'h0);
        chk({name, "_addr"}, 24'(mem.char_addr), 24'h0);
        chk({name, "_fc"}, 24'(mem.font_char), 24'h0);
        chk({name, "_fs"}, 24'(mem.font_scanline), 24'h0);
    endtask

    // Streams one glyph row of cell (col,row) at scanline sc and checks against a literal mask.
    task automatic glyph_row(input string name, input int col, input int row, input int sc,
                             input logic [7:0] mask);
        for (int i = 0; i < 12; i++) begin
            video_active = (i < 8);
            h_count      = 10'(col * 8 + (i < 8 ? i : 0));
            v_count      = 10'(row * 16 + sc);
            step();
            if (i >= 3 && i < 11) chk(name, pixel_rgb, mask[7 - (i - 3)] ? fg_color : bg_color);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0]  = 8'h41;
        ram[82] = 8'hF0;

        rst_n = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Glyph 0x41 scanline 5 returns 0x81: white at both ends.
        fg_color = 24'hFFFFFF;
        bg_color = 24'h000000;
        glyph_row("t1_pix", 0, 0, 5, 8'h81);

        // Bottom-right visible pixel addresses the last cell.
        video_active = 1'b1;
        h_count = 10'd639;
        v_count = 10'd479;
        step();
        chk("t2_addr", 24'(mem.char_addr), 24'd2399);
        video_active = 1'b0;

        // One-cycle sync pulses reappear four edges later.
        for (int k = 0; k < 6; k++) begin
            hsync_in = (k == 0);
            vsync_in = (k == 0);
            step();
            chk("t3_hs", 24'(hsync_out), 24'(k == 3));
            chk("t3_vs", 24'(vsync_out), 24'(k == 3));
        end

        // Mid-line reset at pixel 300 for two cycles.
        v_count = 10'd100;
        for (int h = 290; h < 316; h++) begin
            h_count      = 10'(h);
            video_active = 1'b1;
            fg_color     = 24'($urandom);
            bg_color     = 24'($urandom);
            rst_n        = !(h == 300 || h == 301);
            step();
            if (h == 300 || h == 301) chk_all_zero("t4_rst");
            if (h >= 302 && h <= 304) begin
                chk("t4_pix_bubble", pixel_rgb, 24'h0);
                chk("t4_de_bubble", 24'(de_out), 24'h0);
            end
            if (h == 305) chk("t4_de_valid", 24'(de_out), 24'h1);
        end
        rst_n = 1'b1;

        // Inactive region blanks regardless of position.
        for (int i = 0; i < 8; i++) begin
            video_active = 1'b0;
            h_count      = 10'($urandom_range(0, 639));
            v_count      = 10'($urandom_range(0, 479));
            step();
            if (i >= 3) begin
                chk("t5_pix", pixel_rgb, 24'h0);
                chk("t5_de", 24'(de_out), 24'h0);
            end
        end

`ifdef TEXT_CURSOR_EN
        // Cursor at (2,1): glyph 0xF0 scanline 14 gives 0x22; inverted while blink is on.
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n      = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 5'd1;
        cursor_en  = 1'b1;
        fg_color   = 24'h123456;
        bg_color   = 24'hABCDEF;
        glyph_row("t6_cursor_on", 2, 1, 14, 8'hDD);
        video_active = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vsync_in = 1'b1;
            step();
            vsync_in = 1'b0;
            step();
        end
        glyph_row("t6_cursor_off", 2, 1, 14, 8'h22);
        cursor_en = 1'b0;
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            h_count      = 10'($urandom_range(0, 1023));
            v_count      = 10'($urandom_range(0, 1023));
            video_active = ($urandom_range(0, 9) < 8);
            hsync_in     = ($urandom_range(0, 9) == 0);
            vsync_in     = ($urandom_range(0, 4) == 0);
            fg_color     = 24'($urandom);
            bg_color     = 24'($urandom);
            cursor_en    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                cursor_col = h_count[9:3];
                cursor_row = v_count[8:4];
                v_count[3:1] = 3'b111;
            end else begin
                cursor_col = 7'($urandom_range(0, 127));
                cursor_row = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
